// File: rtl/scmp_bus_target.sv
// ---------------------------------------------------------------------------
// scmp_bus_target
//
// Bus responder for the SC/MP external bus. At the address strobe it latches
// the 16-bit address and the H/D/I/R status flags. If the address falls inside
// the decode window, it serves the following read or write strobe from a
// simple synchronous memory back end. The core is held off with active-low
// bus_HOLD_n until the back-end data is ready.
//
// Optional feature (macro SCMP_BUS_TGT_HALT_EN):
//   When the macro is defined, the block adds the halt_o output and the
//   cont_i input. A read cycle whose latched H flag is set then parks in DONE
//   with halt_o=1 and bus_HOLD_n=0 until cont_i is sampled high.
//   In the default build (macro undefined) these ports do not exist, and the
//   H flag is only reported on flags_o.
//
// Parameters:
//   BASE         window base address, compared under MASK
//   MASK         address bits compared; select = ((addr ^ BASE) & MASK) == 0
//   WAIT_CYCLES  extra hold cycles inserted after mem_ack (0..15)
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   bus_ADS_n           address strobe (active low)
//   bus_RD_n, bus_WR_n  read / write strobes (active low)
//   A_i[11:0]           low 12 address bits
//   D_i[7:0]            data in; during ADS: {H,D,I,R,addr[15:12]}
//   D_o[7:0], D_oe      read data to the core and its enable
//   bus_HOLD_n          active-low wait request to the core
//   flags_o[3:0]        latched {H,D,I,R} of the current cycle
//   sel_o               current cycle decodes inside the window
//   err_o               sticky: RD_n and WR_n seen low together
//   mem_addr[15:0]      back-end address
//   mem_rd, mem_wr      back-end request pulses (one cycle)
//   mem_wdata[7:0]      back-end write data
//   mem_rdata[7:0]      back-end read data, valid with mem_ack
//   mem_ack             back-end completion
//   halt_o, cont_i      halt handshake (SCMP_BUS_TGT_HALT_EN only)
// ---------------------------------------------------------------------------
module scmp_bus_target #(
    parameter logic [15:0] BASE        = 16'h0000,
    parameter logic [15:0] MASK        = 16'hF000,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_ADS_n,
    input  logic        bus_RD_n,
    input  logic        bus_WR_n,
    input  logic [11:0] A_i,
    input  logic [7:0]  D_i,
    output logic [7:0]  D_o,
    output logic        D_oe,
    output logic        bus_HOLD_n,
    output logic [3:0]  flags_o,
    output logic        sel_o,
    output logic        err_o,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
`ifdef SCMP_BUS_TGT_HALT_EN
    input  logic        cont_i,
    output logic        halt_o,
`endif
    input  logic        mem_ack
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        REQ   = 3'd2,
        WAIT  = 3'd3,
        HOLDX = 3'd4,
        DRIVE = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t      r_state;
    logic        r_is_read;   // direction of the cycle being served
    logic        r_abandon;   // strobe released before the back end finished
    logic [3:0]  r_cnt;       // remaining extra hold cycles

    logic [15:0] w_new_addr;
    logic        w_new_sel;
    logic        w_strobe_lost;
    logic        w_abandon;
    logic        w_abort;
    logic        w_finish;
    logic        w_halt_req;

    assign w_new_addr = {D_i[3:0], A_i};
    assign w_new_sel  = ((w_new_addr ^ BASE) & MASK) == 16'h0000;

    // The strobe that matters is the one matching the direction of the cycle.
    assign w_strobe_lost = r_is_read ? bus_RD_n : bus_WR_n;
    assign w_abandon     = r_abandon | w_strobe_lost;

    // A new address strobe outside IDLE/ADDR restarts the bus cycle.
    assign w_abort = !bus_ADS_n &&
                     (r_state inside {REQ, WAIT, HOLDX, DRIVE, DONE});

    // The back-end transaction is complete, including any extra hold cycles.
    assign w_finish = ((r_state == WAIT) && mem_ack && (WAIT_CYCLES == 0)) ||
                      ((r_state == HOLDX) && (r_cnt == 4'd1));

`ifdef SCMP_BUS_TGT_HALT_EN
    assign w_halt_req = r_is_read & flags_o[3];
`else
    assign w_halt_req = 1'b0;
`endif

    // NOTE: all state and registered outputs use non-blocking assignments, so
    // every branch reads the values from before the edge, and a later
    // assignment in the same block (the w_finish override) wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_is_read  <= 1'b0;
            r_abandon  <= 1'b0;
            r_cnt      <= 4'd0;
            D_o        <= 8'h00;
            D_oe       <= 1'b0;
            bus_HOLD_n <= 1'b1;
            flags_o    <= 4'h0;
            sel_o      <= 1'b0;
            err_o      <= 1'b0;
            mem_addr   <= 16'h0000;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_wdata  <= 8'h00;
`ifdef SCMP_BUS_TGT_HALT_EN
            halt_o     <= 1'b0;
`endif
        end else begin
            // Request strobes are single-cycle pulses by default.
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;

            if (w_abort) begin
                // An issued mem_wr is not retracted; only the bus side restarts.
                mem_addr   <= w_new_addr;
                flags_o    <= D_i[7:4];
                sel_o      <= w_new_sel;
                bus_HOLD_n <= 1'b1;
                D_oe       <= 1'b0;
                r_abandon  <= 1'b0;
                r_cnt      <= 4'd0;
`ifdef SCMP_BUS_TGT_HALT_EN
                halt_o     <= 1'b0;
`endif
                r_state    <= ADDR;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (!bus_ADS_n) begin
                            mem_addr <= w_new_addr;
                            flags_o  <= D_i[7:4];
                            sel_o    <= w_new_sel;
                            r_state  <= ADDR;
                        end
                    end

                    ADDR: begin
                        if (!bus_ADS_n) begin
                            // Strobe still low, or a fresh one: track the address.
                            mem_addr <= w_new_addr;
                            flags_o  <= D_i[7:4];
                            sel_o    <= w_new_sel;
                        end else if (!sel_o) begin
                            r_state <= IDLE;
                        end else if (!bus_RD_n && !bus_WR_n) begin
                            err_o <= 1'b1;
                        end else if (!bus_RD_n) begin
                            r_is_read  <= 1'b1;
                            r_abandon  <= 1'b0;
                            mem_rd     <= 1'b1;
                            bus_HOLD_n <= 1'b0;
                            r_state    <= REQ;
                        end else if (!bus_WR_n) begin
                            r_is_read  <= 1'b0;
                            r_abandon  <= 1'b0;
                            mem_wdata  <= D_i;
                            mem_wr     <= 1'b1;
                            bus_HOLD_n <= 1'b0;
                            r_state    <= REQ;
                        end
                    end

                    REQ: begin
                        r_abandon <= w_abandon;
                        r_state   <= WAIT;
                    end

                    WAIT: begin
                        r_abandon <= w_abandon;
                        if (mem_ack) begin
                            if (r_is_read) begin
                                D_o <= mem_rdata;
                            end
                            if (WAIT_CYCLES != 0) begin
                                r_cnt   <= 4'(WAIT_CYCLES);
                                r_state <= HOLDX;
                            end
                        end
                    end

                    HOLDX: begin
                        r_abandon <= w_abandon;
                        r_cnt     <= r_cnt - 4'd1;
                    end

                    DRIVE: begin
                        if (bus_RD_n) begin
                            D_oe       <= 1'b0;
                            bus_HOLD_n <= ~w_halt_req;
`ifdef SCMP_BUS_TGT_HALT_EN
                            halt_o     <= w_halt_req;
`endif
                            r_state    <= DONE;
                        end
                    end

                    DONE: begin
`ifdef SCMP_BUS_TGT_HALT_EN
                        if (halt_o) begin
                            if (cont_i) begin
                                halt_o     <= 1'b0;
                                bus_HOLD_n <= 1'b1;
                                r_state    <= IDLE;
                            end
                        end else
`endif
                        if (bus_RD_n && bus_WR_n) begin
                            r_state <= IDLE;
                        end
                    end

                    default: r_state <= IDLE;
                endcase

                // Completion of the back-end transaction: present the read data,
                // or close the cycle when it was a write or the read was abandoned.
                if (w_finish) begin
                    r_cnt <= 4'd0;
                    if (r_is_read && !w_abandon) begin
                        D_oe       <= 1'b1;
                        bus_HOLD_n <= 1'b1;
                        r_state    <= DRIVE;
                    end else begin
                        bus_HOLD_n <= ~w_halt_req;
`ifdef SCMP_BUS_TGT_HALT_EN
                        halt_o     <= w_halt_req;
`endif
                        r_state    <= DONE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_scmp_bus_target.sv
// ---------------------------------------------------------------------------
// tb_scmp_bus_target
//
// Directed bench for scmp_bus_target. Two instances share the bus and back-end
// inputs:
//   u_dut0  BASE=0000 MASK=0000 WAIT_CYCLES=0  (selects every address)
//   u_dut1  BASE=1000 MASK=F000 WAIT_CYCLES=3  (window 1xxx, extra hold)
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_scmp_bus_target;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bus_ADS_n, bus_RD_n, bus_WR_n;
    logic [11:0] A_i;
    logic [7:0]  D_i;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
`ifdef SCMP_BUS_TGT_HALT_EN
    logic        cont_i;
    logic        d0_halt, d1_halt;
`endif

    logic [7:0]  d0_D_o, d1_D_o;
    logic        d0_D_oe, d1_D_oe;
    logic        d0_hold, d1_hold;
    logic [3:0]  d0_flags, d1_flags;
    logic        d0_sel, d1_sel;
    logic        d0_err, d1_err;
    logic [15:0] d0_maddr, d1_maddr;
    logic        d0_mrd, d1_mrd;
    logic        d0_mwr, d1_mwr;
    logic [7:0]  d0_wdata, d1_wdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    scmp_bus_target #(.BASE(16'h0000), .MASK(16'h0000), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .bus_ADS_n(bus_ADS_n), .bus_RD_n(bus_RD_n), .bus_WR_n(bus_WR_n),
        .A_i(A_i), .D_i(D_i),
        .D_o(d0_D_o), .D_oe(d0_D_oe), .bus_HOLD_n(d0_hold),
        .flags_o(d0_flags), .sel_o(d0_sel), .err_o(d0_err),
        .mem_addr(d0_maddr), .mem_rd(d0_mrd), .mem_wr(d0_mwr),
        .mem_wdata(d0_wdata), .mem_rdata(mem_rdata),
`ifdef SCMP_BUS_TGT_HALT_EN
        .cont_i(cont_i), .halt_o(d0_halt),
`endif
        .mem_ack(mem_ack)
    );

    scmp_bus_target #(.BASE(16'h1000), .MASK(16'hF000), .WAIT_CYCLES(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .bus_ADS_n(bus_ADS_n), .bus_RD_n(bus_RD_n), .bus_WR_n(bus_WR_n),
        .A_i(A_i), .D_i(D_i),
        .D_o(d1_D_o), .D_oe(d1_D_oe), .bus_HOLD_n(d1_hold),
        .flags_o(d1_flags), .sel_o(d1_sel), .err_o(d1_err),
        .mem_addr(d1_maddr), .mem_rd(d1_mrd), .mem_wr(d1_mwr),
        .mem_wdata(d1_wdata), .mem_rdata(mem_rdata),
`ifdef SCMP_BUS_TGT_HALT_EN
        .cont_i(cont_i), .halt_o(d1_halt),
`endif
        .mem_ack(mem_ack)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus_ADS_n = 1'b1; bus_RD_n = 1'b1; bus_WR_n = 1'b1;
        A_i = 12'h000; D_i = 8'h00; mem_rdata = 8'h00; mem_ack = 1'b0;
`ifdef SCMP_BUS_TGT_HALT_EN
        cont_i = 1'b0;
`endif
        tick(); tick();

        // ---- reset values ----
        check("rst_D_o",   d0_D_o,   16'h00);
        check("rst_D_oe",  d0_D_oe,  16'h0);
        check("rst_hold",  d0_hold,  16'h1);
        check("rst_flags", d0_flags, 16'h0);
        check("rst_sel",   d0_sel,   16'h0);
        check("rst_err",   d0_err,   16'h0);
        check("rst_maddr", d0_maddr, 16'h0000);
        check("rst_mrd",   d0_mrd,   16'h0);
        check("rst_mwr",   d0_mwr,   16'h0);
        check("rst_wdata", d0_wdata, 16'h00);
        rst_n = 1'b1;
        tick();

        // ---- read, 1-cycle ack, WAIT_CYCLES=0 (dut0) ----
        bus_ADS_n = 1'b0; A_i = 12'h123; D_i = 8'h05;
        tick();                                   // IDLE -> ADDR
        check("rd_maddr", d0_maddr, 16'h5123);
        check("rd_sel",   d0_sel,   16'h1);
        check("rd_flags", d0_flags, 16'h0);
        check("rd_d1_sel", d1_sel,  16'h0);
        bus_ADS_n = 1'b1; bus_RD_n = 1'b0; mem_rdata = 8'hA5;
        tick();                                   // RD_n sampled low -> REQ
        check("rd_mrd_req",  d0_mrd,  16'h1);
        check("rd_hold_req", d0_hold, 16'h0);
        tick();                                   // REQ -> WAIT
        check("rd_mrd_wait",  d0_mrd,  16'h0);
        check("rd_hold_wait", d0_hold, 16'h0);
        check("rd_oe_wait",   d0_D_oe, 16'h0);
        mem_ack = 1'b1;
        tick();                                   // ack -> DRIVE
        mem_ack = 1'b0;
        check("rd_oe_drive",   d0_D_oe, 16'h1);
        check("rd_dout_drive", d0_D_o,  16'hA5);
        check("rd_hold_drive", d0_hold, 16'h1);
        tick();
        check("rd_oe_keep", d0_D_oe, 16'h1);
        check("rd_mrd_once", d0_mrd, 16'h0);
        bus_RD_n = 1'b1;
        tick();                                   // DRIVE -> DONE
        check("rd_oe_release", d0_D_oe, 16'h0);
        tick();                                   // DONE -> IDLE

        // ---- write, 3-cycle ack (dut0) ----
        bus_ADS_n = 1'b0; A_i = 12'hABC; D_i = 8'h04;
        tick();
        check("wr_maddr", d0_maddr, 16'h4ABC);
        bus_ADS_n = 1'b1; bus_WR_n = 1'b0; D_i = 8'h3C;
        tick();                                   // REQ
        check("wr_mwr_req",  d0_mwr,   16'h1);
        check("wr_wdata",    d0_wdata, 16'h3C);
        check("wr_hold_req", d0_hold,  16'h0);
        tick();                                   // WAIT
        check("wr_mwr_once", d0_mwr,  16'h0);
        check("wr_hold_w1",  d0_hold, 16'h0);
        tick();
        check("wr_hold_w2",  d0_hold, 16'h0);
        check("wr_oe_w2",    d0_D_oe, 16'h0);
        mem_ack = 1'b1;
        tick();                                   // ack -> DONE
        mem_ack = 1'b0;
        check("wr_hold_done", d0_hold, 16'h1);
        check("wr_oe_done",   d0_D_oe, 16'h0);
        bus_WR_n = 1'b1;
        tick();

        // ---- out of window read (dut1, address 2000) ----
        bus_ADS_n = 1'b0; A_i = 12'h000; D_i = 8'h02;
        tick();
        check("oow_sel",  d1_sel,  16'h0);
        check("oow_hold_a", d1_hold, 16'h1);
        bus_ADS_n = 1'b1; bus_RD_n = 1'b0;
        tick();
        check("oow_mrd_1",  d1_mrd,  16'h0);
        check("oow_hold_1", d1_hold, 16'h1);
        tick();
        mem_ack = 1'b1;                           // serves dut0's read
        check("oow_mrd_2",  d1_mrd,  16'h0);
        tick();
        mem_ack = 1'b0;
        check("oow_oe",     d1_D_oe, 16'h0);
        check("oow_hold_3", d1_hold, 16'h1);
        bus_RD_n = 1'b1;
        tick(); tick();

        // ---- WAIT_CYCLES=3 read (dut1, address 1055) ----
        bus_ADS_n = 1'b0; A_i = 12'h055; D_i = 8'h01;
        tick();
        check("wc_sel",   d1_sel,   16'h1);
        check("wc_maddr", d1_maddr, 16'h1055);
        bus_ADS_n = 1'b1; bus_RD_n = 1'b0; mem_rdata = 8'h5A;
        tick();
        check("wc_mrd", d1_mrd, 16'h1);
        tick();
        mem_ack = 1'b1;
        tick();                                   // ack seen -> HOLDX
        mem_ack = 1'b0;
        check("wc_hold_x0", d1_hold, 16'h0);
        check("wc_oe_x0",   d1_D_oe, 16'h0);
        check("wc_dout",    d1_D_o,  16'h5A);
        tick();
        check("wc_hold_x1", d1_hold, 16'h0);
        tick();
        check("wc_hold_x2", d1_hold, 16'h0);
        check("wc_oe_x2",   d1_D_oe, 16'h0);
        tick();
        check("wc_hold_end", d1_hold, 16'h1);
        check("wc_oe_rise",  d1_D_oe, 16'h1);
        bus_RD_n = 1'b1;
        tick();
        check("wc_oe_fall", d1_D_oe, 16'h0);
        tick();

        // ---- error: both strobes low (dut0, address 3000) ----
        bus_ADS_n = 1'b0; A_i = 12'h000; D_i = 8'h03;
        tick();
        bus_ADS_n = 1'b1; bus_RD_n = 1'b0; bus_WR_n = 1'b0;
        tick();
        check("err_set",  d0_err,  16'h1);
        check("err_mrd",  d0_mrd,  16'h0);
        check("err_mwr",  d0_mwr,  16'h0);
        check("err_hold", d0_hold, 16'h1);
        bus_RD_n = 1'b1; bus_WR_n = 1'b1;
        tick();
        check("err_sticky", d0_err, 16'h1);

        // ---- abort: new ADS during WAIT (dut0) ----
        bus_ADS_n = 1'b0; A_i = 12'h200; D_i = 8'h06;
        tick();
        check("ab_maddr1", d0_maddr, 16'h6200);
        bus_ADS_n = 1'b1; bus_RD_n = 1'b0; mem_rdata = 8'h77;
        tick();                                   // REQ
        tick();                                   // WAIT
        check("ab_hold_wait", d0_hold, 16'h0);
        bus_ADS_n = 1'b0; bus_RD_n = 1'b1; A_i = 12'h345; D_i = 8'h07;
        tick();                                   // abort -> ADDR
        check("ab_hold_drop", d0_hold,  16'h1);
        check("ab_maddr2",    d0_maddr, 16'h7345);
        check("ab_oe",        d0_D_oe,  16'h0);
        bus_ADS_n = 1'b1; mem_ack = 1'b1;         // stale ack
        tick();
        mem_ack = 1'b0;
        check("ab_stale_dout", d0_D_o,  16'h5A);
        check("ab_stale_oe",   d0_D_oe, 16'h0);
        check("ab_stale_hold", d0_hold, 16'h1);
        bus_WR_n = 1'b0; D_i = 8'h99;
        tick();
        check("ab_mwr",   d0_mwr,   16'h1);
        check("ab_wdata", d0_wdata, 16'h99);
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("ab_wr_done_hold", d0_hold, 16'h1);
        bus_WR_n = 1'b1;
        tick();
        check("ab_err_still", d0_err, 16'h1);

`ifdef SCMP_BUS_TGT_HALT_EN
        // ---- halt on H flag (dut0) ----
        bus_ADS_n = 1'b0; A_i = 12'h000; D_i = 8'h80;
        tick();
        check("h_flags", d0_flags, 16'h8);
        bus_ADS_n = 1'b1; bus_RD_n = 1'b0;
        tick(); tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        bus_RD_n = 1'b1;
        tick();                                   // DONE entry
        check("h_halt",   d0_halt, 16'h1);
        check("h_hold",   d0_hold, 16'h0);
        tick();
        check("h_halt_keep", d0_halt, 16'h1);
        cont_i = 1'b1;
        tick();
        cont_i = 1'b0;
        check("h_halt_clr", d0_halt, 16'h0);
        check("h_hold_clr", d0_hold, 16'h1);
`endif

        // ---- reset asserted mid-cycle ----
        bus_ADS_n = 1'b0; A_i = 12'h111; D_i = 8'h00;
        tick();
        bus_ADS_n = 1'b1; bus_RD_n = 1'b0;
        tick();                                   // REQ, hold low
        check("mr_hold_pre", d0_hold, 16'h0);
        #2 rst_n = 1'b0;
        #1;
        check("mr_hold", d0_hold,  16'h1);
        check("mr_mrd",  d0_mrd,   16'h0);
        check("mr_addr", d0_maddr, 16'h0000);
        check("mr_err",  d0_err,   16'h0);
        bus_RD_n = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scmp_bus_target.md
Name: scmp_bus_target

Overview:
- Bus responder for the SC/MP external bus: the far end of the core's ADS/RD/WR strobe and status-flag interface.
- Latches the 16-bit address and the H/D/I/R status flags at the address strobe.
- Decodes a window, then serves read or write strobes from a simple synchronous memory back end.
- Stretches each access with active-low hold until back-end data is ready; sits between the core bus pins and on-chip RAM or peripherals.

Parameters:
- BASE, 16'h0000, window base address; compared under MASK.
- MASK, 16'hF000, address bits compared against BASE; select = ((addr ^ BASE) & MASK) == 0.
- WAIT_CYCLES, 0, extra hold cycles inserted after mem_ack (0..15).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- bus_ADS_n  in  1  address strobe, active low.
- bus_RD_n  in  1  read strobe, active low.
- bus_WR_n  in  1  write strobe, active low.
- A_i  in  12  address bus, low 12 bits.
- D_i  in  8  data bus in; during ADS: [7]=H, [6]=D, [5]=I, [4]=R, [3:0]=addr[15:12].
- D_o  out  8  read data driven to core.
- D_oe  out  1  D_o valid/enable.
- bus_HOLD_n  out  1  active-low wait request to core.
- flags_o  out  4  latched {H,D,I,R} of the current cycle.
- sel_o  out  1  current cycle decoded inside window.
- err_o  out  1  sticky: RD_n and WR_n seen low together; cleared only by reset.
- mem_addr  out  16  back-end address.
- mem_rd  out  1  back-end read request, one-cycle pulse.
- mem_wr  out  1  back-end write request, one-cycle pulse.
- mem_wdata  out  8  back-end write data.
- mem_rdata  in  8  back-end read data, valid with mem_ack.
- mem_ack  in  1  back-end completion, may come 1..N cycles after request.

Behaviour:
- Bus strobes are sampled synchronously, with no synchroniser (same clock as core).
- Reset values: D_o=0, D_oe=0, bus_HOLD_n=1, flags_o=0, sel_o=0, err_o=0, mem_addr=0, mem_rd=0, mem_wr=0, mem_wdata=0. FSM=IDLE, wait counter=0.
- FSM states: IDLE, ADDR, REQ, WAIT, HOLDX, DRIVE, DONE.
- IDLE: on bus_ADS_n==0, latch mem_addr={D_i[3:0],A_i} and flags_o=D_i[7:4], compute sel_o, go ADDR.
- ADDR:
  - sel_o==0: return to IDLE on bus_ADS_n==1; never drives or holds.
  - sel_o==1: on RD_n==0 (WR_n==1), go REQ with a read; on WR_n==0 (RD_n==1), capture mem_wdata=D_i and go REQ with a write.
  - Both strobes low: set err_o, stay in ADDR.
- REQ: pulse mem_rd or mem_wr for exactly one cycle; drive bus_HOLD_n=0 from this cycle; go WAIT.
- WAIT: keep hold. On mem_ack: for a read, register D_o=mem_rdata. Then, if WAIT_CYCLES==0, go DRIVE for a read or DONE for a write; otherwise load the counter and go HOLDX.
- HOLDX: decrement the counter each cycle; at 1, go DRIVE/DONE.
- DRIVE: bus_HOLD_n=1, D_oe=1 while RD_n==0; on RD_n==1, D_oe=0 next edge, go DONE.
- DONE: bus_HOLD_n=1; return to IDLE once RD_n==1 and WR_n==1.
- Latency with back end acking in 1 cycle and WAIT_CYCLES=0:
  - mem_rd is asserted the cycle after RD_n is first sampled low.
  - D_oe rises 2 cycles after mem_rd.
  - Hold lasts 2 cycles.
- mem_ack outside WAIT is ignored. Multiple acks count once.
- bus_ADS_n low in any state other than IDLE/ADDR aborts the current cycle:
  - drop hold and D_oe, discard pending ack, relatch the address, go ADDR.
  - An issued mem_wr is not retracted.
- Strobe released while in REQ/WAIT/HOLDX: finish the back-end transaction; do not assert D_oe; go DONE.
- Address compare: 16-bit, no wrap handling needed; MASK=0 selects all addresses.
- Reset asserted mid-cycle: all outputs return to reset values immediately (async).

Optional Feature:
- Macro SCMP_BUS_TGT_HALT_EN adds a halt_o output and a cont_i input.
- Defined:
  - On a read cycle whose latched H flag is 1, halt_o asserts at DONE entry and holds.
  - bus_HOLD_n stays 0 until cont_i is sampled high; then halt_o=0 and the FSM goes IDLE.
  - Reset value halt_o=0.
- Undefined: ports absent; H flag only reported on flags_o.

Test Plan:
- Read, 1-cycle ack, WAIT_CYCLES=0:
  - Stimulus: ADS with A=12'h123, D_i=8'h05; then RD_n low; mem_rdata=8'hA5.
  - Response: mem_addr=16'h5123, single mem_rd pulse, hold 2 cycles, D_o=8'hA5 with D_oe=1 until RD_n high.
- Write with 3-cycle ack latency:
  - Stimulus: WR_n low, D_i=8'h3C.
  - Response: mem_wdata=8'h3C, one mem_wr pulse, bus_HOLD_n low until the cycle after ack, D_oe never high.
- Out of window:
  - Stimulus: BASE=16'h1000, MASK=16'hF000, address 16'h2000 read.
  - Response: sel_o=0, no mem_rd, bus_HOLD_n=1, D_oe=0 throughout.
- WAIT_CYCLES=3 read:
  - Response: hold extends exactly 3 cycles past the ack cycle; D_oe rises on the following edge.
- Error and abort:
  - Stimulus 1: RD_n and WR_n low together in ADDR.
  - Response 1: err_o=1 stays set, no back-end request.
  - Stimulus 2: new ADS during WAIT.
  - Response 2: hold drops, new address latched, stale ack does not drive D_o.
- HALT_EN:
  - Stimulus: read with flags D_i[7]=1.
  - Response: halt_o=1 and hold low until cont_i pulse; then returns to IDLE.
